timer_counter: RTL and testbench

TIMER_COUNTER -- requirements
Module: timer_counter

---
 rtl/timer_counter_pkg.sv | 4 +
 rtl/timer_counter_channel.sv | 60 ++++++
 rtl/timer_counter.sv | 68 ++++++
 tb/tb_timer_counter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/timer_counter_pkg.sv
// Shared constants for the two-channel timer/counter.
package timer_counter_pkg;
  localparam int DEFAULT_WIDTH = 32;
endpackage

// File: rtl/timer_counter_channel.sv
// One counter channel: value register, compare-match flag and one-cycle done pulse.
module timer_counter_channel
  import timer_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             reload,
  input  logic             count_up,
  input  logic             step_en,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] compare_value,
  output logic [WIDTH-1:0] value,
  output logic             done
);

  logic [WIDTH-1:0] value_q;
  logic             match_flag_q;
  logic             done_q;
  logic             match_event;
  logic [WIDTH-1:0] stepped;

  always_comb begin
    match_event = en && (value_q == compare_value) && !match_flag_q;
    stepped     = count_up ? value_q + WIDTH'(1) : value_q - WIDTH'(1);
  end

  // The match flag stops a value parked on compare from re-firing every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      value_q      <= '0;
      match_flag_q <= 1'b0;
      done_q       <= 1'b0;
    end else if (!en) begin
      value_q      <= load_value;
      match_flag_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= match_event;
      if (match_event) begin
        if (reload) begin
          value_q      <= load_value;
          match_flag_q <= 1'b0;
        end else begin
          if (step_en) value_q <= stepped;
          match_flag_q <= 1'b1;
        end
      end else begin
        if (step_en) value_q <= stepped;
        if (value_q != compare_value) match_flag_q <= 1'b0;
      end
    end
  end

  assign value = value_q;
  assign done  = done_q;

endmodule

// File: rtl/timer_counter.sv
// Two compare/reload counters; counter1 can be clocked by counter0 match pulses.
module timer_counter
  import timer_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_cnt0_en,
  input  logic             i_cnt0_reload,
  input  logic             i_cnt0_count_up,
  input  logic [WIDTH-1:0] i_cnt0_load_value,
  input  logic [WIDTH-1:0] i_cnt0_compare_value,
  input  logic             i_cnt1_en,
  input  logic             i_cnt1_reload,
  input  logic             i_cnt1_count_up,
  input  logic [WIDTH-1:0] i_cnt1_load_value,
  input  logic [WIDTH-1:0] i_cnt1_compare_value,
  input  logic             i_cnt1_src,
  output logic             o_cnt0_done,
  output logic             o_cnt1_done,
  output logic [WIDTH-1:0] o_cnt0_value,
  output logic [WIDTH-1:0] o_cnt1_value
);

  logic [WIDTH-1:0] s_cnt0_value;
  logic [WIDTH-1:0] s_cnt1_value;
  logic             s_cnt0_done;
  logic             s_cnt1_done;
  logic             cnt0_step;
  logic             cnt1_step;

  assign cnt0_step = i_cnt0_en;
  // In cascade mode counter1 advances once per registered counter0 match pulse.
  assign cnt1_step = i_cnt1_en & (i_cnt1_src ? s_cnt0_done : 1'b1);

  timer_counter_channel #(.WIDTH(WIDTH)) u_cnt0 (
    .clk           (clk),
    .rst           (rst),
    .en            (i_cnt0_en),
    .reload        (i_cnt0_reload),
    .count_up      (i_cnt0_count_up),
    .step_en       (cnt0_step),
    .load_value    (i_cnt0_load_value),
    .compare_value (i_cnt0_compare_value),
    .value         (s_cnt0_value),
    .done          (s_cnt0_done)
  );

  timer_counter_channel #(.WIDTH(WIDTH)) u_cnt1 (
    .clk           (clk),
    .rst           (rst),
    .en            (i_cnt1_en),
    .reload        (i_cnt1_reload),
    .count_up      (i_cnt1_count_up),
    .step_en       (cnt1_step),
    .load_value    (i_cnt1_load_value),
    .compare_value (i_cnt1_compare_value),
    .value         (s_cnt1_value),
    .done          (s_cnt1_done)
  );

  assign o_cnt0_value = s_cnt0_value;
  assign o_cnt1_value = s_cnt1_value;
  assign o_cnt0_done  = s_cnt0_done;
  assign o_cnt1_done  = s_cnt1_done;

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: periods, direction, wrap, cascade and reset abort.
module tb_timer_counter;
  localparam int W = 32;

  logic         tb_clk = 1'b0;
  logic         rst;
  logic         i_cnt0_en, i_cnt0_reload, i_cnt0_count_up;
  logic [W-1:0] i_cnt0_load_value, i_cnt0_compare_value;
  logic         i_cnt1_en, i_cnt1_reload, i_cnt1_count_up, i_cnt1_src;
  logic [W-1:0] i_cnt1_load_value, i_cnt1_compare_value;
  logic         o_cnt0_done, o_cnt1_done;
  logic [W-1:0] o_cnt0_value, o_cnt1_value;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  always #5 tb_clk = ~tb_clk;

  timer_counter #(.WIDTH(W)) dut (
    .clk                  (tb_clk),
    .rst                  (rst),
    .i_cnt0_en            (i_cnt0_en),
    .i_cnt0_reload        (i_cnt0_reload),
    .i_cnt0_count_up      (i_cnt0_count_up),
    .i_cnt0_load_value    (i_cnt0_load_value),
    .i_cnt0_compare_value (i_cnt0_compare_value),
    .i_cnt1_en            (i_cnt1_en),
    .i_cnt1_reload        (i_cnt1_reload),
    .i_cnt1_count_up      (i_cnt1_count_up),
    .i_cnt1_load_value    (i_cnt1_load_value),
    .i_cnt1_compare_value (i_cnt1_compare_value),
    .i_cnt1_src           (i_cnt1_src),
    .o_cnt0_done          (o_cnt0_done),
    .o_cnt1_done          (o_cnt1_done),
    .o_cnt0_value         (o_cnt0_value),
    .o_cnt1_value         (o_cnt1_value)
  );

  // Advance one edge, then settle before driving or sampling.
  task automatic tick();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic setup0(input logic up, input logic rl, input logic [W-1:0] ld, input logic [W-1:0] cmp);
    i_cnt0_en = 1'b0; i_cnt0_count_up = up; i_cnt0_reload = rl;
    i_cnt0_load_value = ld; i_cnt0_compare_value = cmp;
    tick();
    i_cnt0_en = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_cnt0_en = 1'b1; i_cnt1_en = 1'b1;
    i_cnt0_load_value = 32'd9; i_cnt1_load_value = 32'd9;
    tick(); tick();
    chk_cnt++; if (o_cnt0_value !== 32'd0) $display("FAIL reset_v0: got %0d exp 0", o_cnt0_value); else pass_cnt++;
    chk_cnt++; if (o_cnt1_value !== 32'd0) $display("FAIL reset_v1: got %0d exp 0", o_cnt1_value); else pass_cnt++;
    chk_cnt++; if (o_cnt0_done !== 1'b0) $display("FAIL reset_d0: got %b exp 0", o_cnt0_done); else pass_cnt++;
    chk_cnt++; if (o_cnt1_done !== 1'b0) $display("FAIL reset_d1: got %b exp 0", o_cnt1_done); else pass_cnt++;
    i_cnt0_en = 1'b0; i_cnt1_en = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_up_reload();
    int first = -1, second = -1, n = 0;
    logic [W-1:0] v50 = '0, v101 = '0;
    setup0(1'b1, 1'b1, 32'd0, 32'd100);
    for (int i = 1; i <= 250; i++) begin
      tick();
      if (o_cnt0_done === 1'b1) begin
        n++;
        if (first < 0) first = i; else if (second < 0) second = i;
      end
      if (i == 50)  v50  = o_cnt0_value;
      if (i == 101) v101 = o_cnt0_value;
    end
    chk_cnt++; if (v50 !== 32'd50) $display("FAIL up_mid_value: got %0d exp 50", v50); else pass_cnt++;
    chk_cnt++; if (first !== 101) $display("FAIL up_first_done: got %0d exp 101", first); else pass_cnt++;
    chk_cnt++; if (second !== 202) $display("FAIL up_second_done: got %0d exp 202", second); else pass_cnt++;
    chk_cnt++; if (n !== 2) $display("FAIL up_done_cycles: got %0d exp 2", n); else pass_cnt++;
    chk_cnt++; if (v101 !== 32'd0) $display("FAIL up_reload_value: got %0d exp 0", v101); else pass_cnt++;
  endtask

  task automatic test_disable();
    i_cnt0_en = 1'b0; i_cnt0_load_value = 32'd77;
    tick();
    chk_cnt++; if (o_cnt0_value !== 32'd77) $display("FAIL disable_value: got %0d exp 77", o_cnt0_value); else pass_cnt++;
    chk_cnt++; if (o_cnt0_done !== 1'b0) $display("FAIL disable_done: got %b exp 0", o_cnt0_done); else pass_cnt++;
  endtask

  task automatic test_no_reload();
    int first = -1, n = 0;
    logic [W-1:0] v101 = '0, v106 = '0;
    setup0(1'b1, 1'b0, 32'd0, 32'd100);
    for (int i = 1; i <= 250; i++) begin
      tick();
      if (o_cnt0_done === 1'b1) begin n++; if (first < 0) first = i; end
      if (i == 101) v101 = o_cnt0_value;
      if (i == 106) v106 = o_cnt0_value;
    end
    chk_cnt++; if (first !== 101) $display("FAIL norl_first_done: got %0d exp 101", first); else pass_cnt++;
    chk_cnt++; if (v101 !== 32'd101) $display("FAIL norl_step_on_match: got %0d exp 101", v101); else pass_cnt++;
    chk_cnt++; if (v106 !== 32'd106) $display("FAIL norl_past_compare: got %0d exp 106", v106); else pass_cnt++;
    chk_cnt++; if (n !== 1) $display("FAIL norl_done_count: got %0d exp 1", n); else pass_cnt++;
  endtask

  task automatic test_down();
    int first = -1, second = -1;
    logic [W-1:0] v40 = '0, v101 = '0, vw = '0;
    setup0(1'b0, 1'b1, 32'd100, 32'd0);
    for (int i = 1; i <= 210; i++) begin
      tick();
      if (o_cnt0_done === 1'b1) begin
        if (first < 0) first = i; else if (second < 0) second = i;
      end
      if (i == 40)  v40  = o_cnt0_value;
      if (i == 101) v101 = o_cnt0_value;
    end
    chk_cnt++; if (v40 !== 32'd60) $display("FAIL down_mid_value: got %0d exp 60", v40); else pass_cnt++;
    chk_cnt++; if (first !== 101) $display("FAIL down_first_done: got %0d exp 101", first); else pass_cnt++;
    chk_cnt++; if (second !== 202) $display("FAIL down_second_done: got %0d exp 202", second); else pass_cnt++;
    chk_cnt++; if (v101 !== 32'd100) $display("FAIL down_reload_value: got %0d exp 100", v101); else pass_cnt++;
    setup0(1'b0, 1'b0, 32'd100, 32'd0);
    for (int i = 1; i <= 101; i++) tick();
    vw = o_cnt0_value;
    chk_cnt++; if (vw !== 32'hFFFF_FFFF) $display("FAIL down_wrap: got %0h exp ffffffff", vw); else pass_cnt++;
  endtask

  task automatic test_cnt1_free();
    int first = -1, second = -1;
    i_cnt0_en = 1'b0;
    i_cnt1_en = 1'b0; i_cnt1_src = 1'b0; i_cnt1_count_up = 1'b1; i_cnt1_reload = 1'b1;
    i_cnt1_load_value = 32'd0; i_cnt1_compare_value = 32'd100;
    tick();
    i_cnt1_en = 1'b1;
    for (int i = 1; i <= 210; i++) begin
      tick();
      if (o_cnt1_done === 1'b1) begin
        if (first < 0) first = i; else if (second < 0) second = i;
      end
    end
    chk_cnt++; if (first !== 101) $display("FAIL cnt1_first_done: got %0d exp 101", first); else pass_cnt++;
    chk_cnt++; if (second !== 202) $display("FAIL cnt1_second_done: got %0d exp 202", second); else pass_cnt++;
    chk_cnt++; if (o_cnt0_done !== 1'b0) $display("FAIL cnt0_idle_independent: got %b exp 0", o_cnt0_done); else pass_cnt++;
  endtask

  task automatic test_cascade(input logic rl);
    int first = -1, n = 0;
    logic [W-1:0] v101 = '0, v102 = '0, v506 = '0, v507 = '0, v607 = '0;
    logic d508 = 1'b1;
    i_cnt0_en = 1'b0; i_cnt0_count_up = 1'b1; i_cnt0_reload = 1'b1;
    i_cnt0_load_value = 32'd0; i_cnt0_compare_value = 32'd100;
    i_cnt1_en = 1'b0; i_cnt1_src = 1'b1; i_cnt1_count_up = 1'b1; i_cnt1_reload = rl;
    i_cnt1_load_value = 32'd0; i_cnt1_compare_value = 32'd5;
    tick();
    i_cnt0_en = 1'b1; i_cnt1_en = 1'b1;
    for (int i = 1; i <= 610; i++) begin
      tick();
      if (o_cnt1_done === 1'b1) begin n++; if (first < 0) first = i; end
      if (i == 101) v101 = o_cnt1_value;
      if (i == 102) v102 = o_cnt1_value;
      if (i == 506) v506 = o_cnt1_value;
      if (i == 507) v507 = o_cnt1_value;
      if (i == 508) d508 = o_cnt1_done;
      if (i == 607) v607 = o_cnt1_value;
    end
    chk_cnt++; if (v101 !== 32'd0) $display("FAIL casc_before_step: got %0d exp 0", v101); else pass_cnt++;
    chk_cnt++; if (v102 !== 32'd1) $display("FAIL casc_first_step: got %0d exp 1", v102); else pass_cnt++;
    chk_cnt++; if (v506 !== 32'd5) $display("FAIL casc_fifth_step: got %0d exp 5", v506); else pass_cnt++;
    chk_cnt++; if (first !== 507) $display("FAIL casc_done_time: got %0d exp 507", first); else pass_cnt++;
    chk_cnt++; if (d508 !== 1'b0) $display("FAIL casc_done_width: got %b exp 0", d508); else pass_cnt++;
    if (rl) begin
      chk_cnt++; if (v507 !== 32'd0) $display("FAIL casc_reload_value: got %0d exp 0", v507); else pass_cnt++;
      chk_cnt++; if (v607 !== 32'd1) $display("FAIL casc_after_reload: got %0d exp 1", v607); else pass_cnt++;
    end else begin
      chk_cnt++; if (v507 !== 32'd5) $display("FAIL hold_at_compare: got %0d exp 5", v507); else pass_cnt++;
      chk_cnt++; if (n !== 1) $display("FAIL hold_single_pulse: got %0d exp 1", n); else pass_cnt++;
      chk_cnt++; if (v607 !== 32'd6) $display("FAIL hold_resume_step: got %0d exp 6", v607); else pass_cnt++;
    end
  endtask

  task automatic test_load_eq_compare();
    int n = 0;
    setup0(1'b1, 1'b1, 32'd7, 32'd7);
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (o_cnt0_done === 1'b1) n++;
    end
    chk_cnt++; if (n !== 5) $display("FAIL eq_done_every_cycle: got %0d exp 5", n); else pass_cnt++;
    chk_cnt++; if (o_cnt0_value !== 32'd7) $display("FAIL eq_value: got %0d exp 7", o_cnt0_value); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    setup0(1'b1, 1'b1, 32'd0, 32'd100);
    i_cnt1_en = 1'b0; i_cnt1_src = 1'b0; i_cnt1_reload = 1'b1; i_cnt1_count_up = 1'b1;
    i_cnt1_load_value = 32'd0; i_cnt1_compare_value = 32'd3;
    tick();
    i_cnt1_en = 1'b1;
    for (int i = 1; i <= 49; i++) tick();
    chk_cnt++; if (o_cnt0_value !== 32'd50) $display("FAIL mid_pre_reset: got %0d exp 50", o_cnt0_value); else pass_cnt++;
    rst = 1'b1;
    tick();
    chk_cnt++; if (o_cnt0_value !== 32'd0) $display("FAIL mid_reset_v0: got %0d exp 0", o_cnt0_value); else pass_cnt++;
    chk_cnt++; if (o_cnt1_value !== 32'd0) $display("FAIL mid_reset_v1: got %0d exp 0", o_cnt1_value); else pass_cnt++;
    chk_cnt++; if ({o_cnt0_done, o_cnt1_done} !== 2'b00) $display("FAIL mid_reset_done: got %b exp 00", {o_cnt0_done, o_cnt1_done}); else pass_cnt++;
    rst = 1'b0;
    for (int i = 1; i <= 10; i++) tick();
    chk_cnt++; if (o_cnt0_value !== 32'd10) $display("FAIL mid_resume: got %0d exp 10", o_cnt0_value); else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1;
    i_cnt0_en = 1'b0; i_cnt0_reload = 1'b0; i_cnt0_count_up = 1'b1;
    i_cnt0_load_value = '0; i_cnt0_compare_value = '0;
    i_cnt1_en = 1'b0; i_cnt1_reload = 1'b0; i_cnt1_count_up = 1'b1; i_cnt1_src = 1'b0;
    i_cnt1_load_value = '0; i_cnt1_compare_value = '0;
    test_reset();
    test_up_reload();
    test_disable();
    test_no_reload();
    test_down();
    test_cnt1_free();
    test_cascade(1'b1);
    test_cascade(1'b0);
    test_load_eq_compare();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
